// File: rtl/lane_slice_transposer.sv
// lane_slice_transposer
//   Collects a 25-lane matrix (one Count-bit lane per lane handshake, lanes
//   arriving in order 0..24). It then streams the matrix back out as Count
//   25-bit slices. Slice z carries bit z of every lane, and lane i lands on
//   bit i of the slice.
//
// Ports
//   clk              sole clock, rising edge
//   rst              asynchronous, active-low reset
//   laneIn           lane word; its lane index is implied by arrival order
//   laneValid/Ready  lane input handshake
//   sliceOut         current slice (forced to 0 while sliceValid=0)
//   sliceValid/Ready slice output handshake
//   busy             matrix partially loaded, being sent, or completing
//   done             one-cycle pulse after the last slice is accepted
//   dbg_state_o      FSM state (0=LOAD, 1=SEND, 2=DONE)
//   dbg_slice_cnt_o  index of the slice currently presented
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds its data stable while
// valid=1 and ready=0. Valid on an interface whose ready is 0 has no effect.
module lane_slice_transposer #(
  parameter  int Count = 64,
  localparam int CW    = (Count > 1) ? $clog2(Count) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Count-1:0] laneIn,
  input  logic             laneValid,
  output logic             laneReady,
  output logic [24:0]      sliceOut,
  output logic             sliceValid,
  input  logic             sliceReady,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o,
  output logic [CW-1:0]    dbg_slice_cnt_o
);

  localparam int Lanes = 25;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [4:0]       lane_cnt_q;
  logic [CW-1:0]    slice_cnt_q;
  logic [Count-1:0] lanes_q [Lanes];

  logic             lane_ready_q;
  logic             slice_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [24:0]      slice_mux;

  // Outputs are decoded into flops together with the next state, so every
  // control output is a clean register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOAD;
      lane_cnt_q    <= '0;
      slice_cnt_q   <= '0;
      lane_ready_q  <= 1'b1;
      slice_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < Lanes; i++) lanes_q[i] <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (laneValid) begin
            lanes_q[lane_cnt_q] <= laneIn;
            busy_q              <= 1'b1;
            if (lane_cnt_q == 5'd24) begin
              lane_cnt_q    <= '0;
              state_q       <= SEND;
              lane_ready_q  <= 1'b0;
              slice_valid_q <= 1'b1;
            end else begin
              lane_cnt_q <= lane_cnt_q + 5'd1;
            end
          end
        end
        SEND: begin
          // Without sliceReady, the counter (and therefore sliceOut) holds.
          if (sliceReady) begin
            if (slice_cnt_q == CW'(Count - 1)) begin
              slice_cnt_q   <= '0;
              state_q       <= DONE;
              slice_valid_q <= 1'b0;
              done_q        <= 1'b1;
            end else begin
              slice_cnt_q <= slice_cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          state_q      <= LOAD;
          done_q       <= 1'b0;
          lane_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q       <= LOAD;
          lane_cnt_q    <= '0;
          slice_cnt_q   <= '0;
          lane_ready_q  <= 1'b1;
          slice_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

  // Transpose read: pick column slice_cnt_q out of every stored lane.
  always_comb begin
    slice_mux = '0;
    for (int i = 0; i < Lanes; i++) slice_mux[i] = lanes_q[i][slice_cnt_q];
  end

  assign sliceOut        = slice_valid_q ? slice_mux : 25'd0;
  assign laneReady       = lane_ready_q;
  assign sliceValid      = slice_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign dbg_state_o     = state_q;
  assign dbg_slice_cnt_o = slice_cnt_q;

endmodule

// File: tb/tb_lane_slice_transposer.sv
// Testbench for lane_slice_transposer (Count = 64).
// Reference model: the expected slice z is bit z of every lane in the matrix,
// computed when the matrix is loaded and queued in exp_q.
module tb_lane_slice_transposer;

  localparam int COUNT = 64;
  localparam int CW    = 6;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [COUNT-1:0] laneIn = '0;
  logic             laneValid = 1'b0;
  logic             laneReady;
  logic [24:0]      sliceOut;
  logic             sliceValid;
  logic             sliceReady = 1'b0;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state_o;
  logic [CW-1:0]    dbg_slice_cnt_o;

  always #5 clk = ~clk;

  lane_slice_transposer #(.Count(COUNT)) dut (
    .clk             (clk),
    .rst             (rst),
    .laneIn          (laneIn),
    .laneValid       (laneValid),
    .laneReady       (laneReady),
    .sliceOut        (sliceOut),
    .sliceValid      (sliceValid),
    .sliceReady      (sliceReady),
    .busy            (busy),
    .done            (done),
    .dbg_state_o     (dbg_state_o),
    .dbg_slice_cnt_o (dbg_slice_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  int               done_cnt = 0;
  int               exp_dones = 0;
  logic [24:0]      exp_q[$];
  logic [COUNT-1:0] cur_lanes [25];
  bit               hold_valid = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference transpose: the expected slices come straight from the lane words.
  task automatic model_push();
    logic [24:0] s;
    for (int z = 0; z < COUNT; z++) begin
      s = '0;
      for (int i = 0; i < 25; i++) s[i] = cur_lanes[i][z];
      exp_q.push_back(s);
    end
  endtask

  task automatic load_matrix();
    int guard;
    model_push();
    for (int i = 0; i < 25; i++) begin
      guard = 0;
      while (laneReady !== 1'b1 && guard < 20) begin
        if (hold_valid) begin laneValid = 1'b1; laneIn = {$urandom, $urandom}; end
        step();
        guard++;
      end
      if (guard >= 20) chk("lane_ready_wait", {63'd0, laneReady}, 64'd1);
      laneValid = 1'b1;
      laneIn    = cur_lanes[i];
      step();
      if (i == 0) begin
        chk("busy_partial", {63'd0, busy}, 64'd1);
        chk("state_load", {62'd0, dbg_state_o}, 64'd0);
      end
    end
    if (hold_valid) laneIn = {$urandom, $urandom};
    else laneValid = 1'b0;
    chk("slice_valid_latency", {63'd0, sliceValid}, 64'd1);
    chk("lane_ready_send", {63'd0, laneReady}, 64'd0);
  endtask

  // mode: 0 model only, 1 diagonal constant, 2 single-lane constant
  task automatic recv(input int n, input int mode);
    logic [24:0] e;
    int z;
    for (int k = 0; k < n; k++) begin
      z = COUNT - exp_q.size();
      sliceReady = 1'b1;
      if (hold_valid) laneIn = {$urandom, $urandom};
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 64'd1, 64'd0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      chk("slice_valid", {63'd0, sliceValid}, 64'd1);
      chk("slice_data", {39'd0, sliceOut}, {39'd0, e});
      if (mode == 1) chk("diag_const", {39'd0, sliceOut}, (z < 25) ? (64'd1 << z) : 64'd0);
      if (mode == 2) chk("single_lane_const", {39'd0, sliceOut}, 64'h8);
      step();
    end
  endtask

  task automatic finish_matrix();
    exp_dones++;
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("done_slice_valid", {63'd0, sliceValid}, 64'd0);
    chk("done_slice_out", {39'd0, sliceOut}, 64'd0);
    chk("done_lane_ready", {63'd0, laneReady}, 64'd0);
    chk("exp_q_empty", exp_q.size(), 64'd0);
    sliceReady = 1'b0;
    step();
    chk("done_single", {63'd0, done}, 64'd0);
    chk("lane_ready_after_done", {63'd0, laneReady}, 64'd1);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("done_count", done_cnt, exp_dones);
  endtask

  task automatic random_lanes();
    for (int i = 0; i < 25; i++) cur_lanes[i] = {$urandom, $urandom};
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Asynchronous reset between edges.
    #3 rst = 1'b0;
    #1;
    chk("rst_lane_ready", {63'd0, laneReady}, 64'd1);
    chk("rst_slice_valid", {63'd0, sliceValid}, 64'd0);
    chk("rst_slice_out", {39'd0, sliceOut}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Diagonal matrix.
    for (int i = 0; i < 25; i++) cur_lanes[i] = 64'd1 << i;
    load_matrix();
    recv(COUNT, 1);
    finish_matrix();

    // Single lane of ones.
    for (int i = 0; i < 25; i++) cur_lanes[i] = '0;
    cur_lanes[3] = '1;
    load_matrix();
    recv(COUNT, 2);
    finish_matrix();

    // Backpressure at slice 5.
    random_lanes();
    load_matrix();
    recv(5, 0);
    sliceReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_data", {39'd0, sliceOut}, {39'd0, exp_q[0]});
      chk("bp_hold_cnt", {58'd0, dbg_slice_cnt_o}, 64'd5);
      chk("bp_hold_valid", {63'd0, sliceValid}, 64'd1);
      step();
    end
    recv(COUNT - 5, 0);
    finish_matrix();

    // Reset in the middle of SEND.
    random_lanes();
    load_matrix();
    recv(30, 0);
    chk("mid_cnt_30", {58'd0, dbg_slice_cnt_o}, 64'd30);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_state", {62'd0, dbg_state_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_slice_valid", {63'd0, sliceValid}, 64'd0);
    chk("mid_rst_slice_out", {39'd0, sliceOut}, 64'd0);
    chk("mid_rst_lane_ready", {63'd0, laneReady}, 64'd1);
    exp_q.delete();
    sliceReady = 1'b0;
    step();
    rst = 1'b1;
    random_lanes();
    load_matrix();
    recv(COUNT, 0);
    finish_matrix();

    // Back-to-back matrices with laneValid held high throughout.
    hold_valid = 1;
    random_lanes();
    load_matrix();
    recv(COUNT, 0);
    finish_matrix();
    random_lanes();
    load_matrix();
    recv(COUNT, 0);
    finish_matrix();
    hold_valid = 0;
    laneValid  = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_slice_transposer.md
LANE_SLICE_TRANSPOSER -- requirements
Module: lane_slice_transposer

Interface
REQ-001 The block SHALL have parameter Count, default 64, giving lane width in bits and number of slices per matrix.
REQ-002 The block SHALL have a fixed lane count of 25 and slice width of 25 bits.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous and active-low; one clock.
REQ-005 Port laneIn  input  Count  lane word, lane index implied by arrival order 0..24.
REQ-006 Port laneValid  input  1  laneIn is valid this cycle.
REQ-007 Port laneReady  output  1  block accepts a lane this cycle.
REQ-008 Port sliceOut  output  25  current slice; bit i is lane i.
REQ-009 Port sliceValid  output  1  sliceOut is valid this cycle.
REQ-010 Port sliceReady  input  1  downstream (column-parity datapath matrixIn side) accepts the slice.
REQ-011 Port busy  output  1  a matrix is partially loaded, being sent, or completing.
REQ-012 Port done  output  1  one-cycle pulse after the last slice is accepted.

Function
REQ-013 The FSM SHALL have three states: LOAD, SEND and DONE.
REQ-014 A lane handshake SHALL occur on a rising edge where laneValid and laneReady are both 1; a slice handshake SHALL occur where sliceValid and sliceReady are both 1.
REQ-015 In LOAD: laneReady=1, sliceValid=0, done=0; each lane handshake stores laneIn as lane laneCnt and increments laneCnt (0..24).
REQ-016 The lane handshake with laneCnt=24 SHALL clear laneCnt and move to SEND; sliceValid SHALL be 1 from the next cycle (1-cycle latency).
REQ-017 In SEND: laneReady=0, sliceValid=1, sliceOut[i] = bit sliceCnt of stored lane i; slices are emitted in order sliceCnt 0..Count-1.
REQ-018 Each slice handshake SHALL increment sliceCnt; a handshake with sliceCnt=Count-1 SHALL clear sliceCnt and move to DONE.
REQ-019 While sliceValid=1 and sliceReady=0, sliceOut and sliceCnt SHALL hold unchanged indefinitely.
REQ-020 DONE SHALL last exactly one cycle with done=1, laneReady=0, sliceValid=0, then return to LOAD.
REQ-021 sliceOut SHALL be 0 whenever sliceValid=0.
REQ-022 busy SHALL be 1 in SEND or DONE, or in LOAD with laneCnt≠0; otherwise 0.
REQ-023 laneValid SHALL be ignored outside LOAD and sliceReady SHALL be ignored outside SEND; no lane data is lost or duplicated.
REQ-024 Stored lane contents SHALL be overwritten only by lane handshakes; there SHALL be no clear between matrices.
REQ-025 Back-to-back matrices SHALL be supported: minimum turnaround of one DONE cycle between the last slice handshake and the first new lane handshake.

Reset
REQ-026 rst=0 SHALL immediately force state=LOAD, laneCnt=0, sliceCnt=0 and all lane storage to 0, independent of clk.
REQ-027 Output values during and after reset SHALL be: laneReady=1, sliceValid=0, sliceOut=0, busy=0, done=0.
REQ-028 Reset asserted mid-LOAD or mid-SEND SHALL abandon the matrix; the next lane handshake after reset SHALL be taken as lane 0.

Verification
REQ-029 Reset: assert rst=0 asynchronously between edges -> laneReady=1, sliceValid=0, sliceOut=0, busy=0, done=0 immediately.
REQ-030 Diagonal: lane i = 1<<i for i=0..24, sliceReady=1 -> sliceValid rises one cycle after lane 24; slice z = 25'h1<<z for z=0..24; slices 25..63 = 0; done pulses once, one cycle after slice 63.
REQ-031 Single lane: lane 3 = all ones, others 0 -> all 64 slices = 25'h0000008.
REQ-032 Backpressure: random lanes, sliceReady=0 for 10 cycles while sliceCnt=5 -> sliceOut holds slice 5 unchanged, sliceCnt stays 5, and slice 6 follows the first handshake.
REQ-033 Mid-send reset: rst=0 while sliceCnt=30 -> LOAD, busy=0; a new matrix then streams correctly from slice 0.
REQ-034 Back-to-back: two matrices with laneValid held at 1 -> exactly one done pulse per matrix, laneReady=1 the cycle after done, and second matrix slices are bit-exact.
